// File: rtl/tag_pkg.sv
// Shared types for the tag-stream replayer: tag field widths, the tag record
// and the replay FSM state encoding.
package tag_pkg;
    localparam int unsigned TIME_WIDTH    = 64;
    localparam int unsigned CHANNEL_WIDTH = 6;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]    tagtime;
        logic [CHANNEL_WIDTH-1:0] channel;
    } tag_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;
endpackage

// File: rtl/tag_lane_classifier.sv
// Classifies one lane's tag time against the current replay window
// [window_start, window_start + PERIOD_PS); purely combinational.
module tag_lane_classifier
    import tag_pkg::*;
#(
    parameter int unsigned PERIOD_PS = 4000
) (
    input  logic [TIME_WIDTH-1:0] tagtime_i,
    input  logic [TIME_WIDTH-1:0] window_start_i,
    output logic                  early_o,
    output logic                  in_window_o,
    output logic                  future_o
);
    logic [TIME_WIDTH-1:0] window_end;

    // The window end may wrap modulo 2^TIME_WIDTH; that case is tolerated as-is.
    always_comb begin
        window_end  = window_start_i + TIME_WIDTH'(PERIOD_PS);
        early_o     = tagtime_i < window_start_i;
        future_o    = !early_o && (tagtime_i >= window_end);
        in_window_o = !early_o && !future_o;
    end
endmodule

// File: rtl/tag_event_replayer.sv
// Replays a sorted time-tag stream as per-channel one-cycle event pulses,
// one clock cycle per PERIOD_PS window of tag time.
module tag_event_replayer
    import tag_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 2,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned PERIOD_PS  = 4000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic [WORD_WIDTH-1:0]             s_tkeep,
    input  logic [WORD_WIDTH*TIME_WIDTH-1:0]  s_tagtime,
    input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
    output logic [CHANNELS-1:0]               events,
    output logic [TIME_WIDTH-1:0]             window_start,
    output logic                              running,
    output logic [31:0]                       late_count
);
    state_e                    state_q, state_d;
    tag_t [WORD_WIDTH-1:0]     hold_q, hold_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [WORD_WIDTH-1:0]     done_q, done_d;
    logic [TIME_WIDTH-1:0]     ws_q, ws_d;
    logic [CHANNELS-1:0]       ev_q, ev_d;
    logic [31:0]               late_q, late_d;

    logic [WORD_WIDTH-1:0]     early, in_win, future;
    logic [WORD_WIDTH-1:0]     pending, done_next;
    logic                      complete, load, found;
    logic [TIME_WIDTH-1:0]     anchor;

    for (genvar g = 0; g < WORD_WIDTH; g++) begin : g_lane
        tag_lane_classifier #(.PERIOD_PS(PERIOD_PS)) u_cls (
            .tagtime_i      (hold_q[g].tagtime),
            .window_start_i (ws_q),
            .early_o        (early[g]),
            .in_window_o    (in_win[g]),
            .future_o       (future[g])
        );
    end

    always_comb begin
        pending   = (hold_valid_q && state_q == RUN) ? ~done_q : '0;
        done_next = done_q | (pending & ~future);
        complete  = hold_valid_q && (state_q == RUN) && (&done_next);
        s_tready  = enable && (!hold_valid_q || complete);
        load      = s_tvalid && s_tready && (|s_tkeep);

        // IDLE anchors the time base on the lowest kept lane of the held beat.
        found  = 1'b0;
        anchor = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            if (!found && !done_q[i]) begin
                anchor = hold_q[i].tagtime;
                found  = 1'b1;
            end
        end

        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = done_q;
        ws_d         = ws_q;
        ev_d         = '0;
        late_d       = late_q;

        if (!enable) begin
            state_d      = IDLE;
            hold_valid_d = 1'b0;
            done_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hold_valid_q) begin
                        ws_d    = anchor;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    ws_d   = ws_q + TIME_WIDTH'(PERIOD_PS);
                    done_d = done_next;
                    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            if (pending[i] && in_win[i] && hold_q[i].channel == CHANNEL_WIDTH'(c))
                                ev_d[c] = 1'b1;
                        end
                        if (pending[i] && early[i] && late_d != '1)
                            late_d = late_d + 32'd1;
                    end
                    if (complete)
                        hold_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase

            // An empty-keep beat is accepted but never occupies the hold register.
            if (load) begin
                for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
                    hold_d[i].tagtime = s_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
                    hold_d[i].channel = s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                end
                done_d       = ~s_tkeep;
                hold_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            done_q       <= '0;
            ws_q         <= '0;
            ev_q         <= '0;
            late_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            ws_q         <= ws_d;
            ev_q         <= ev_d;
            late_q       <= late_d;
        end
    end

    assign events       = ev_q;
    assign window_start = ws_q;
    assign running      = (state_q == RUN);
    assign late_count   = late_q;
endmodule

// File: tb/tb_tag_event_replayer.sv
// Self-checking bench for tag_event_replayer: cycle table with hand-derived
// expectations, event pulses checked through a scoreboard queue.
module tb_tag_event_replayer;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          s_tvalid;
    logic          s_tready;
    logic [1:0]    s_tkeep;
    logic [127:0]  s_tagtime;
    logic [11:0]   s_channel;
    logic [3:0]    events;
    logic [63:0]   window_start;
    logic          running;
    logic [31:0]   late_count;

    int checks   = 0;
    int failures = 0;

    tag_event_replayer #(.WORD_WIDTH(2), .CHANNELS(4), .PERIOD_PS(4000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tkeep      (s_tkeep),
        .s_tagtime    (s_tagtime),
        .s_channel    (s_channel),
        .events       (events),
        .window_start (window_start),
        .running      (running),
        .late_count   (late_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  keep;
        logic [63:0] t0;
        logic [5:0]  c0;
        logic [63:0] t1;
        logic [5:0]  c1;
        logic        exp_ready;
        logic [3:0]  exp_ev;
        logic [63:0] exp_ws;
        logic        exp_run;
        logic [31:0] exp_late;
    } row_t;

    typedef struct {
        logic [3:0]  ev;
        logic [63:0] ws;
    } exp_ev_t;

    exp_ev_t sbq[$];
    row_t    rows[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [63:0] t0,
                         input logic [5:0] c0, input logic [63:0] t1, input logic [5:0] c1);
        s_tvalid  = v;
        s_tkeep   = k;
        s_tagtime = {t1, t0};
        s_channel = {c1, c0};
    endtask

    task automatic push_ev(input logic [3:0] ev, input logic [63:0] ws);
        exp_ev_t e;
        e.ev = ev;
        e.ws = ws;
        sbq.push_back(e);
    endtask

    // Advance one clock and match any event pulse against the scoreboard.
    task automatic tick();
        exp_ev_t e;
        @(posedge clk);
        #1;
        if (events !== 4'd0) begin
            if (sbq.size() == 0) begin
                check("unexpected_event", 64'(events), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("event_mask", 64'(events), 64'(e.ev));
                check("event_ws", window_start, e.ws);
            end
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        @(negedge clk);
        check(name, 64'(s_tready), 64'(exp));
    endtask

    initial begin
        //          v  keep  t0       c0  t1      c1  rdy ev       ws       run late
        rows[0]  = '{1, 2'b01, 1000,   1, 0,      0,  1, 4'b0000, 0,      0, 0};
        rows[1]  = '{1, 2'b11, 5000,   0, 13500,  2,  0, 4'b0000, 1000,   1, 0};
        rows[2]  = '{1, 2'b11, 5000,   0, 13500,  2,  1, 4'b0010, 5000,   1, 0};
        rows[3]  = '{0, 2'b00, 0,      0, 0,      0,  0, 4'b0001, 9000,   1, 0};
        rows[4]  = '{0, 2'b00, 0,      0, 0,      0,  0, 4'b0000, 13000,  1, 0};
        rows[5]  = '{1, 2'b01, 500,    3, 0,      0,  1, 4'b0100, 17000,  1, 0};
        rows[6]  = '{0, 2'b00, 0,      0, 0,      0,  1, 4'b0000, 21000,  1, 1};
        rows[7]  = '{1, 2'b11, 26000,  2, 27000,  2,  1, 4'b0000, 25000,  1, 1};
        rows[8]  = '{0, 2'b00, 0,      0, 0,      0,  1, 4'b0100, 29000,  1, 1};
        rows[9]  = '{1, 2'b11, 33000,  0, 36999,  3,  1, 4'b0000, 33000,  1, 1};
        rows[10] = '{0, 2'b00, 0,      0, 0,      0,  1, 4'b1001, 37000,  1, 1};
        rows[11] = '{1, 2'b01, 42000,  7, 0,      0,  1, 4'b0000, 41000,  1, 1};
        rows[12] = '{1, 2'b00, 999,    1, 999,    2,  1, 4'b0000, 45000,  1, 1};
        rows[13] = '{1, 2'b00, 999,    1, 999,    2,  1, 4'b0000, 49000,  1, 1};
        rows[14] = '{0, 2'b00, 0,      0, 0,      0,  1, 4'b0000, 53000,  1, 1};

        rst_n  = 1'b0;
        enable = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        #1;
        check("reset_events", 64'(events), 64'd0);
        check("reset_ws", window_start, 64'd0);
        check("reset_running", 64'(running), 64'd0);
        check("reset_late", 64'(late_count), 64'd0);
        check("reset_ready", 64'(s_tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            enable = 1'b1;
            drive(rows[i].valid, rows[i].keep, rows[i].t0, rows[i].c0, rows[i].t1, rows[i].c1);
            if (rows[i].exp_ev != 4'd0)
                push_ev(rows[i].exp_ev, rows[i].exp_ws);
            check_ready($sformatf("row%0d_ready", i), rows[i].exp_ready);
            tick();
            check($sformatf("row%0d_ws", i), window_start, rows[i].exp_ws);
            check($sformatf("row%0d_running", i), 64'(running), 64'(rows[i].exp_run));
            check($sformatf("row%0d_late", i), 64'(late_count), 64'(rows[i].exp_late));
        end

        // Disable in RUN, then re-anchor on a fresh tag.
        enable = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        check_ready("dis_ready", 1'b0);
        tick();
        check("dis_running", 64'(running), 64'd0);
        check("dis_late", 64'(late_count), 64'd1);
        drive(1, 2'b01, 50000, 1, 0, 0);
        check_ready("dis_ready_valid", 1'b0);
        tick();
        check("dis_running2", 64'(running), 64'd0);
        enable = 1'b1;
        check_ready("reen_ready", 1'b1);
        tick();
        check("reen_running", 64'(running), 64'd0);
        drive(0, 2'b00, 0, 0, 0, 0);
        check_ready("anchor_ready", 1'b0);
        tick();
        check("anchor_running", 64'(running), 64'd1);
        check("anchor_ws", window_start, 64'd50000);
        push_ev(4'b0010, 64'd54000);
        check_ready("anchor_run_ready", 1'b1);
        tick();
        check("anchor_next_ws", window_start, 64'd54000);

        // Two late lanes in one cycle add two to the counter.
        drive(1, 2'b11, 100, 0, 200, 1);
        check_ready("late2_ready", 1'b1);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0);
        check_ready("late2_done_ready", 1'b1);
        tick();
        check("late2_count", 64'(late_count), 64'd3);
        check("late2_ws", window_start, 64'd62000);

        // Asynchronous reset while a far-future beat is stalled.
        drive(1, 2'b01, 1000000, 2, 0, 0);
        check_ready("stall_load_ready", 1'b1);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0);
        check_ready("stall_ready", 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_events", 64'(events), 64'd0);
        check("arst_ws", window_start, 64'd0);
        check("arst_running", 64'(running), 64'd0);
        check("arst_late", 64'(late_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(s_tready), 64'd1);
        tick();
        check("post_rst_running", 64'(running), 64'd0);
        check("post_rst_ws", window_start, 64'd0);
        tick();
        check("post_rst_running2", 64'(running), 64'd0);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
